lsu_tlbrd_seq: RTL and testbench

LSU_TLBRD_SEQ -- requirements
Module: lsu_tlbrd_seq

---
 rtl/lsu_tlbrd_seq.sv | 153 +++++++++++++++
 tb/tb_lsu_tlbrd_seq.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_tlbrd_seq.sv
// TLB read sequencer: round-robin arbitration of per-thread TTE tag/data reads,
// fixed 4-cycle IDLE/ISSUE/WAIT/RESP sequence, parity check and error logging.
module lsu_tlbrd_seq #(
    parameter int NTHR   = 4,
    parameter int TAG_W  = 59,
    parameter int DATA_W = 43,
    parameter int IDX_W  = 6,
    parameter int CNT_W  = 8
) (
    input  logic                  rclk,
    input  logic                  arst_l,
    input  logic [NTHR-1:0]       rd_req,
    input  logic [NTHR-1:0]       rd_is_data,
    input  logic [NTHR*IDX_W-1:0] rd_idx,
    input  logic [NTHR-1:0]       rd_kill,
    output logic                  tlb_rd_en,
    output logic [IDX_W-1:0]      tlb_rd_idx,
    input  logic [TAG_W-1:0]      tlb_rd_tte_tag,
    input  logic [DATA_W-1:0]     tlb_rd_tte_data,
    input  logic                  tlb_rd_tte_tag_parity,
    input  logic                  tlb_rd_tte_data_parity,
    output logic [NTHR-1:0]       rd_ack,
    output logic [63:0]           rd_data,
    output logic                  rd_perr,
    input  logic [NTHR-1:0]       perr_clr,
    output logic [NTHR-1:0]       perr_log,
    input  logic                  perr_cnt_clr,
    output logic [CNT_W-1:0]      perr_cnt
);

    localparam int PTR_W = (NTHR > 1) ? $clog2(NTHR) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t           r_state;
    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] r_grant;
    logic             r_is_data;
    logic             r_killed;
    logic             r_err;
    logic             r_tlb_en;
    logic [IDX_W-1:0] r_tlb_idx;
    logic [63:0]      r_rd_data;
    logic [NTHR-1:0]  r_log;
    logic [CNT_W-1:0] r_cnt;

    logic [NTHR-1:0]  w_elig;
    logic             w_found;
    logic [PTR_W-1:0] w_gnt;
    logic [PTR_W-1:0] w_cand;
    logic [PTR_W-1:0] w_ptr_nxt;
    logic             w_kill_now;
    logic             w_dead;
    logic             w_tag_err;
    logic             w_data_err;
    logic             w_err;
    logic             w_resp_ok;
    logic             w_inc;
    logic [NTHR-1:0]  w_onehot;
    logic [NTHR-1:0]  w_set;

    // First eligible thread at or after the pointer, wrapping.
    always_comb begin
        w_elig  = rd_req & ~rd_kill;
        w_found = 1'b0;
        w_gnt   = '0;
        w_cand  = '0;
        for (int i = 0; i < NTHR; i++) begin
            w_cand = PTR_W'((int'(r_ptr) + i) % NTHR);
            if (!w_found && w_elig[w_cand]) begin
                w_found = 1'b1;
                w_gnt   = w_cand;
            end
        end
    end

    assign w_ptr_nxt  = (w_gnt == PTR_W'(NTHR - 1)) ? '0 : w_gnt + PTR_W'(1);
    assign w_kill_now = rd_kill[r_grant];
    assign w_dead     = r_killed | w_kill_now;
    assign w_tag_err  = tlb_rd_tte_tag_parity ^ (^tlb_rd_tte_tag);
    assign w_data_err = tlb_rd_tte_data_parity ^ (^tlb_rd_tte_data);
    assign w_err      = r_is_data ? w_data_err : w_tag_err;
    // A kill on the granted thread arriving as late as RESP still squashes the response.
    assign w_resp_ok  = (r_state == S_RESP) && !w_dead;
    assign w_onehot   = NTHR'(1) << r_grant;
    assign w_inc      = w_resp_ok && r_err;
    assign w_set      = w_inc ? w_onehot : '0;

    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            r_state   <= S_IDLE;
            r_ptr     <= '0;
            r_grant   <= '0;
            r_is_data <= 1'b0;
            r_killed  <= 1'b0;
            r_err     <= 1'b0;
            r_tlb_en  <= 1'b0;
            r_tlb_idx <= '0;
            r_rd_data <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_state   <= S_ISSUE;
                        r_grant   <= w_gnt;
                        r_is_data <= rd_is_data[w_gnt];
                        r_tlb_idx <= rd_idx[w_gnt*IDX_W +: IDX_W];
                        r_ptr     <= w_ptr_nxt;
                        r_tlb_en  <= 1'b1;
                        r_killed  <= 1'b0;
                    end
                end
                S_ISSUE: begin
                    r_state  <= S_WAIT;
                    r_tlb_en <= 1'b0;
                    if (w_kill_now) r_killed <= 1'b1;
                end
                S_WAIT: begin
                    r_state  <= S_RESP;
                    r_killed <= w_dead;
                    r_err    <= w_err;
                    // rd_data only moves for a response that may still be acked.
                    if (!w_dead)
                        r_rd_data <= r_is_data ? 64'(tlb_rd_tte_data) : 64'(tlb_rd_tte_tag);
                end
                S_RESP: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            r_log <= '0;
            r_cnt <= '0;
        end else begin
            r_log <= (r_log & ~perr_clr) | w_set;
            if (perr_cnt_clr)
                r_cnt <= w_inc ? CNT_W'(1) : '0;
            else if (w_inc && !(&r_cnt))
                r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign tlb_rd_en  = r_tlb_en;
    assign tlb_rd_idx = r_tlb_idx;
    assign rd_ack     = w_resp_ok ? w_onehot : '0;
    assign rd_data    = r_rd_data;
    assign rd_perr    = w_inc;
    assign perr_log   = r_log;
    assign perr_cnt   = r_cnt;

endmodule

// File: tb/tb_lsu_tlbrd_seq.sv
// Directed bench for lsu_tlbrd_seq: latency, round-robin, parity logging,
// counter saturation, kill and mid-sequence reset.
module tb_lsu_tlbrd_seq;

    localparam int NTHR   = 4;
    localparam int TAG_W  = 59;
    localparam int DATA_W = 43;
    localparam int IDX_W  = 6;
    localparam int CNT_W  = 2;

    logic                  rclk;
    logic                  arst_l;
    logic [NTHR-1:0]       rd_req;
    logic [NTHR-1:0]       rd_is_data;
    logic [NTHR*IDX_W-1:0] rd_idx;
    logic [NTHR-1:0]       rd_kill;
    logic                  tlb_rd_en;
    logic [IDX_W-1:0]      tlb_rd_idx;
    logic [TAG_W-1:0]      tlb_rd_tte_tag;
    logic [DATA_W-1:0]     tlb_rd_tte_data;
    logic                  tlb_rd_tte_tag_parity;
    logic                  tlb_rd_tte_data_parity;
    logic [NTHR-1:0]       rd_ack;
    logic [63:0]           rd_data;
    logic                  rd_perr;
    logic [NTHR-1:0]       perr_clr;
    logic [NTHR-1:0]       perr_log;
    logic                  perr_cnt_clr;
    logic [CNT_W-1:0]      perr_cnt;

    int total;
    int bad;

    lsu_tlbrd_seq #(
        .NTHR(NTHR), .TAG_W(TAG_W), .DATA_W(DATA_W), .IDX_W(IDX_W), .CNT_W(CNT_W)
    ) dut (
        .rclk(rclk), .arst_l(arst_l),
        .rd_req(rd_req), .rd_is_data(rd_is_data), .rd_idx(rd_idx), .rd_kill(rd_kill),
        .tlb_rd_en(tlb_rd_en), .tlb_rd_idx(tlb_rd_idx),
        .tlb_rd_tte_tag(tlb_rd_tte_tag), .tlb_rd_tte_data(tlb_rd_tte_data),
        .tlb_rd_tte_tag_parity(tlb_rd_tte_tag_parity),
        .tlb_rd_tte_data_parity(tlb_rd_tte_data_parity),
        .rd_ack(rd_ack), .rd_data(rd_data), .rd_perr(rd_perr),
        .perr_clr(perr_clr), .perr_log(perr_log),
        .perr_cnt_clr(perr_cnt_clr), .perr_cnt(perr_cnt)
    );

    always #5 rclk = ~rclk;

    task automatic step();
        @(negedge rclk);
    endtask

    task automatic do_reset();
        rd_req       = '0;
        rd_kill      = '0;
        perr_clr     = '0;
        perr_cnt_clr = 1'b0;
        arst_l       = 1'b0;
        step();
        step();
        arst_l = 1'b1;
    endtask

    // Drives one request from an IDLE negedge and stops at the RESP negedge.
    task automatic run_read(input int t, input logic isd, input logic [IDX_W-1:0] idx);
        rd_req = '0;
        rd_req[t] = 1'b1;
        rd_is_data[t] = isd;
        rd_idx[t*IDX_W +: IDX_W] = idx;
        step();
        step();
        step();
    endtask

    task automatic test_reset();
        rclk = 1'b0;
        rd_is_data = '0;
        rd_idx = '0;
        tlb_rd_tte_tag = '0;
        tlb_rd_tte_data = '0;
        tlb_rd_tte_tag_parity = 1'b0;
        tlb_rd_tte_data_parity = 1'b0;
        do_reset();
        total++;
        if ({tlb_rd_en, tlb_rd_idx, rd_ack, rd_data, rd_perr, perr_log, perr_cnt} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: en=%b idx=%0d ack=%b data=%h perr=%b log=%b cnt=%0d want all 0",
                     tlb_rd_en, tlb_rd_idx, rd_ack, rd_data, rd_perr, perr_log, perr_cnt);
        end
    endtask

    task automatic test_single_tag();
        tlb_rd_tte_tag = 59'h1234;
        tlb_rd_tte_tag_parity = 1'b1;
        tlb_rd_tte_data = 43'h7;
        tlb_rd_tte_data_parity = 1'b0;
        rd_req = 4'b0100;
        rd_is_data = '0;
        rd_idx[2*IDX_W +: IDX_W] = 6'd5;
        step();
        total++;
        if (tlb_rd_en !== 1'b1 || tlb_rd_idx !== 6'd5) begin
            bad++;
            $display("FAIL single_issue: en=%b idx=%0d want en=1 idx=5", tlb_rd_en, tlb_rd_idx);
        end
        step();
        total++;
        if (tlb_rd_en !== 1'b0 || rd_ack !== 4'b0000) begin
            bad++;
            $display("FAIL single_wait: en=%b ack=%b want en=0 ack=0000", tlb_rd_en, rd_ack);
        end
        step();
        total++;
        if (rd_ack !== 4'b0100 || rd_data !== 64'h1234 || rd_perr !== 1'b0) begin
            bad++;
            $display("FAIL single_resp: ack=%b data=%h perr=%b want 0100 1234 0", rd_ack, rd_data, rd_perr);
        end
        rd_req = '0;
        step();
        total++;
        if (rd_ack !== 4'b0000 || rd_data !== 64'h1234) begin
            bad++;
            $display("FAIL single_hold: ack=%b data=%h want 0000 1234", rd_ack, rd_data);
        end
    endtask

    task automatic test_round_robin();
        logic [NTHR-1:0] exp_ack [5];
        exp_ack = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        rd_req = 4'b1111;
        rd_is_data = '0;
        for (int t = 0; t < NTHR; t++) rd_idx[t*IDX_W +: IDX_W] = IDX_W'(10 + t);
        for (int k = 0; k < 5; k++) begin
            step();
            total++;
            if (tlb_rd_idx !== IDX_W'(10 + (k % 4))) begin
                bad++;
                $display("FAIL rr_idx[%0d]: idx=%0d want %0d", k, tlb_rd_idx, 10 + (k % 4));
            end
            step();
            step();
            total++;
            if (rd_ack !== exp_ack[k]) begin
                bad++;
                $display("FAIL rr_ack[%0d]: ack=%b want %b", k, rd_ack, exp_ack[k]);
            end
            step();
            total++;
            if (tlb_rd_en !== 1'b0 || rd_ack !== 4'b0000) begin
                bad++;
                $display("FAIL rr_gap[%0d]: en=%b ack=%b want 0 0000", k, tlb_rd_en, rd_ack);
            end
        end
        rd_req = '0;
    endtask

    task automatic test_data_perr();
        do_reset();
        tlb_rd_tte_data = 43'h3;
        tlb_rd_tte_data_parity = 1'b1;
        tlb_rd_tte_tag = 59'h1234;
        tlb_rd_tte_tag_parity = 1'b1;
        run_read(1, 1'b1, 6'd7);
        total++;
        if (rd_ack !== 4'b0010 || rd_perr !== 1'b1 || rd_data !== 64'h3) begin
            bad++;
            $display("FAIL perr_resp: ack=%b perr=%b data=%h want 0010 1 3", rd_ack, rd_perr, rd_data);
        end
        rd_req = '0;
        step();
        total++;
        if (perr_log !== 4'b0010 || perr_cnt !== 2'd1 || rd_perr !== 1'b0) begin
            bad++;
            $display("FAIL perr_log1: log=%b cnt=%0d perr=%b want 0010 1 0", perr_log, perr_cnt, rd_perr);
        end
        run_read(1, 1'b1, 6'd7);
        perr_clr = 4'b0010;
        rd_req = '0;
        step();
        total++;
        if (perr_log !== 4'b0010 || perr_cnt !== 2'd2) begin
            bad++;
            $display("FAIL perr_set_wins: log=%b cnt=%0d want 0010 2", perr_log, perr_cnt);
        end
        step();
        perr_clr = '0;
        total++;
        if (perr_log !== 4'b0000) begin
            bad++;
            $display("FAIL perr_clear: log=%b want 0000", perr_log);
        end
        // Tag read with good tag parity: the bad data parity must not be reported.
        run_read(2, 1'b0, 6'd8);
        total++;
        if (rd_ack !== 4'b0100 || rd_perr !== 1'b0 || rd_data !== 64'h1234) begin
            bad++;
            $display("FAIL perr_select: ack=%b perr=%b data=%h want 0100 0 1234", rd_ack, rd_perr, rd_data);
        end
        rd_req = '0;
        step();
        total++;
        if (perr_cnt !== 2'd2 || perr_log !== 4'b0000) begin
            bad++;
            $display("FAIL perr_select_log: cnt=%0d log=%b want 2 0000", perr_cnt, perr_log);
        end
    endtask

    task automatic test_saturation();
        logic [CNT_W-1:0] exp_cnt [5];
        exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        do_reset();
        tlb_rd_tte_tag = 59'h1;
        tlb_rd_tte_tag_parity = 1'b0;
        for (int k = 0; k < 5; k++) begin
            run_read(0, 1'b0, 6'd3);
            rd_req = '0;
            step();
            total++;
            if (perr_cnt !== exp_cnt[k]) begin
                bad++;
                $display("FAIL sat_cnt[%0d]: cnt=%0d want %0d", k, perr_cnt, exp_cnt[k]);
            end
        end
        run_read(0, 1'b0, 6'd3);
        perr_cnt_clr = 1'b1;
        rd_req = '0;
        step();
        perr_cnt_clr = 1'b0;
        total++;
        if (perr_cnt !== 2'd1) begin
            bad++;
            $display("FAIL sat_clr_inc: cnt=%0d want 1", perr_cnt);
        end
        perr_cnt_clr = 1'b1;
        step();
        perr_cnt_clr = 1'b0;
        total++;
        if (perr_cnt !== 2'd0) begin
            bad++;
            $display("FAIL sat_clr: cnt=%0d want 0", perr_cnt);
        end
    endtask

    task automatic test_kill();
        do_reset();
        tlb_rd_tte_data = 43'h3;
        tlb_rd_tte_data_parity = 1'b1;
        rd_req = 4'b0001;
        rd_is_data = 4'b0001;
        rd_idx[0 +: IDX_W] = 6'd2;
        step();
        step();
        rd_kill = 4'b0001;
        step();
        total++;
        if (rd_ack !== 4'b0000 || rd_perr !== 1'b0) begin
            bad++;
            $display("FAIL kill_resp: ack=%b perr=%b want 0000 0", rd_ack, rd_perr);
        end
        rd_kill = '0;
        rd_req = '0;
        step();
        total++;
        if (perr_log !== 4'b0000 || perr_cnt !== 2'd0) begin
            bad++;
            $display("FAIL kill_log: log=%b cnt=%0d want 0000 0", perr_log, perr_cnt);
        end
        tlb_rd_tte_tag = 59'h1234;
        tlb_rd_tte_tag_parity = 1'b1;
        run_read(3, 1'b0, 6'd4);
        total++;
        if (rd_ack !== 4'b1000 || rd_data !== 64'h1234 || rd_perr !== 1'b0) begin
            bad++;
            $display("FAIL kill_next: ack=%b data=%h perr=%b want 1000 1234 0", rd_ack, rd_data, rd_perr);
        end
        rd_req = '0;
        step();
    endtask

    task automatic test_reset_mid();
        tlb_rd_tte_data = 43'h3;
        tlb_rd_tte_data_parity = 1'b1;
        run_read(1, 1'b1, 6'd7);
        rd_req = '0;
        step();
        total++;
        if (perr_log !== 4'b0010 || perr_cnt !== 2'd1) begin
            bad++;
            $display("FAIL rmid_pre: log=%b cnt=%0d want 0010 1", perr_log, perr_cnt);
        end
        rd_req = 4'b0100;
        rd_is_data = '0;
        rd_idx[2*IDX_W +: IDX_W] = 6'd9;
        step();
        step();
        arst_l = 1'b0;
        #1;
        total++;
        if ({tlb_rd_en, tlb_rd_idx, rd_ack, rd_data, rd_perr, perr_log, perr_cnt} !== '0) begin
            bad++;
            $display("FAIL rmid_async: en=%b idx=%0d ack=%b data=%h perr=%b log=%b cnt=%0d want all 0",
                     tlb_rd_en, tlb_rd_idx, rd_ack, rd_data, rd_perr, perr_log, perr_cnt);
        end
        rd_req = '0;
        step();
        arst_l = 1'b1;
        step();
        tlb_rd_tte_tag = 59'h55;
        tlb_rd_tte_tag_parity = 1'b0;
        rd_req = 4'b1000;
        rd_idx[3*IDX_W +: IDX_W] = 6'd1;
        step();
        step();
        total++;
        if (rd_ack !== 4'b0000) begin
            bad++;
            $display("FAIL rmid_early: ack=%b want 0000", rd_ack);
        end
        step();
        total++;
        if (rd_ack !== 4'b1000 || rd_data !== 64'h55 || rd_perr !== 1'b0) begin
            bad++;
            $display("FAIL rmid_ack: ack=%b data=%h perr=%b want 1000 55 0", rd_ack, rd_data, rd_perr);
        end
        rd_req = '0;
        step();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_single_tag();
        test_round_robin();
        test_data_perr();
        test_saturation();
        test_kill();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: sim time limit reached, want bench to finish");
        $fatal(1, "timeout");
    end

endmodule
